// File: rtl/unsigned_divider_16by8_seq.sv
// Sequential unsigned 16-by-8 restoring divider with valid/ready handshakes.
// One operation in flight; 8 iterations on the normal path, immediate result on exceptions.
module unsigned_divider_16by8_seq #(
  parameter int unsigned TRUNC_L = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] z,
  input  logic [7:0]  y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  q,
  output logic [7:0]  r,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  localparam logic [15:0] ZMASK = 16'hFFFF << TRUNC_L;

  state_t      state_q;
  logic [7:0]  pr_q;      // partial remainder; bit 8 of the 9-bit form is always 0 between steps
  logic [7:0]  div_q;     // latched divisor
  logic [7:0]  sh_q;      // remaining dividend bits out of the MSB, quotient bits into the LSB
  logic [2:0]  cnt_q;
  logic [7:0]  q_q, r_q;
  logic        dbz_q, ovf_q;

  logic [15:0] zd;
  logic [8:0]  t;
  logic        ge;
  logic [7:0]  pr_d, sh_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    zd   = z & ZMASK;
    t    = {pr_q, sh_q[7]};
    ge   = (t >= {1'b0, div_q});
    pr_d = t[7:0];
    if (ge) pr_d = t[7:0] - div_q;  // t - y < y <= 255, so 8-bit arithmetic is exact
    sh_d = {sh_q[6:0], ge};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pr_q    <= '0;
      div_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (y == 8'h00) begin
              q_q     <= 8'hFF;
              r_q     <= 8'h00;
              dbz_q   <= 1'b1;
              ovf_q   <= 1'b0;
              state_q <= S_DONE;
            end else if (zd[15:8] >= y) begin
              q_q     <= 8'hFF;
              r_q     <= 8'h00;
              dbz_q   <= 1'b0;
              ovf_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              div_q   <= y;
              pr_q    <= zd[15:8];
              sh_q    <= zd[7:0];
              cnt_q   <= '0;
              state_q <= S_DIV;
            end
          end
        end
        S_DIV: begin
          pr_q  <= pr_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            q_q     <= sh_d;
            r_q     <= pr_d;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_unsigned_divider_16by8_seq.sv
// Directed self-checking bench for unsigned_divider_16by8_seq (TRUNC_L=0 and TRUNC_L=2 instances).
module tb_unsigned_divider_16by8_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [15:0] z;
  logic [7:0]  y;
  logic        in_ready, out_valid, div_by_zero, overflow;
  logic [7:0]  q, r;

  logic        t_in_valid, t_out_ready;
  logic [15:0] t_z;
  logic [7:0]  t_y;
  logic        t_in_ready, t_out_valid, t_dbz, t_ovf;
  logic [7:0]  t_q, t_r;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  unsigned_divider_16by8_seq #(.TRUNC_L(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .z(z), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .r(r), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  unsigned_divider_16by8_seq #(.TRUNC_L(2)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .z(t_z), .y(t_y), .out_valid(t_out_valid), .out_ready(t_out_ready),
    .q(t_q), .r(t_r), .div_by_zero(t_dbz), .overflow(t_ovf)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request, wait (bounded) until in_ready, return #1 after the accepting edge.
  task automatic issue(input logic [15:0] zz, input logic [7:0] yy);
    int n;
    @(negedge clk);
    z = zz; y = yy; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    z = 16'hA5A5; y = 8'h01;  // scramble operands after acceptance
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if ({q, r} !== 16'h0000) begin n_err++; $display("FAIL reset_qr: got %h expected 0000", {q, r}); end
    n_cmp++; if ({div_by_zero, overflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b expected 00", {div_by_zero, overflow}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    int lat;
    issue(16'h1234, 8'h56);
    wait_valid(lat);
    n_cmp++; if (lat != 8) begin n_err++; $display("FAIL normal_latency: got %0d expected 8", lat); end
    n_cmp++; if (q !== 8'h36) begin n_err++; $display("FAIL normal_q: got %h expected 36", q); end
    n_cmp++; if (r !== 8'h10) begin n_err++; $display("FAIL normal_r: got %h expected 10", r); end
    n_cmp++; if ({div_by_zero, overflow} !== 2'b00) begin n_err++; $display("FAIL normal_flags: got %b expected 00", {div_by_zero, overflow}); end
    consume();
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL normal_post_handshake: got rdy/vld %b expected 10", {in_ready, out_valid}); end
    n_cmp++; if ({q, r} !== 16'h3610) begin n_err++; $display("FAIL normal_qr_kept: got %h expected 3610", {q, r}); end
  endtask

  task automatic test_full_scale();
    int lat;
    issue(16'hFE01, 8'hFF);
    wait_valid(lat);
    n_cmp++; if (lat != 8) begin n_err++; $display("FAIL full_latency: got %0d expected 8", lat); end
    n_cmp++; if ({q, r} !== 16'hFF00) begin n_err++; $display("FAIL full_qr: got %h expected FF00", {q, r}); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_overflow: got %b expected 0", overflow); end
    consume();
  endtask

  // Products x*y must invert exactly: q == x, r == 0.
  task automatic test_products();
    logic [7:0] xs [0:6];
    logic [7:0] ys [0:6];
    int lat;
    xs = '{8'd0, 8'd255, 8'd17, 8'd200, 8'd1, 8'd128, 8'd99};
    ys = '{8'd1, 8'd255, 8'd13, 8'd3,   8'd1, 8'd2,   8'd254};
    for (int i = 0; i < 7; i++) begin
      issue(16'(xs[i]) * 16'(ys[i]), ys[i]);
      wait_valid(lat);
      n_cmp++;
      if (lat != 8 || q !== xs[i] || r !== 8'h00 || {div_by_zero, overflow} !== 2'b00) begin
        n_err++;
        $display("FAIL product_%0d: got lat=%0d q=%h r=%h flags=%b expected lat=8 q=%h r=00 flags=00",
                 i, lat, q, r, {div_by_zero, overflow}, xs[i]);
      end
      consume();
    end
  endtask

  task automatic test_exceptions();
    int lat;
    issue(16'h0100, 8'h00);
    wait_valid(lat);
    n_cmp++; if (lat != 0) begin n_err++; $display("FAIL dbz_latency: got %0d expected 0", lat); end
    n_cmp++; if ({q, r, div_by_zero, overflow} !== {16'hFF00, 2'b10}) begin n_err++; $display("FAIL dbz_result: got q=%h r=%h dbz=%b ovf=%b expected q=FF r=00 dbz=1 ovf=0", q, r, div_by_zero, overflow); end
    consume();
    n_cmp++; if ({div_by_zero, in_ready} !== 2'b01) begin n_err++; $display("FAIL dbz_cleared: got dbz/rdy %b expected 01", {div_by_zero, in_ready}); end
    issue(16'h1000, 8'h10);
    wait_valid(lat);
    n_cmp++; if (lat != 0) begin n_err++; $display("FAIL ovf_latency: got %0d expected 0", lat); end
    n_cmp++; if ({q, r, div_by_zero, overflow} !== {16'hFF00, 2'b01}) begin n_err++; $display("FAIL ovf_result: got q=%h r=%h dbz=%b ovf=%b expected q=FF r=00 dbz=0 ovf=1", q, r, div_by_zero, overflow); end
    consume();
    issue(16'hFFFF, 8'h00);
    wait_valid(lat);
    n_cmp++; if ({div_by_zero, overflow} !== 2'b10) begin n_err++; $display("FAIL priority_flags: got dbz/ovf %b expected 10", {div_by_zero, overflow}); end
    consume();
  endtask

  task automatic test_trunc();
    logic [15:0] zs [0:1];
    logic [7:0]  ys [0:1];
    logic [7:0]  qs [0:1];
    int lat;
    zs = '{16'h0007, 16'h0403};
    ys = '{8'h01, 8'h08};
    qs = '{8'h04, 8'h80};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      t_z = zs[i]; t_y = ys[i]; t_in_valid = 1'b1;
      @(posedge clk);
      #1;
      t_in_valid = 1'b0;
      lat = 0;
      while (t_out_valid !== 1'b1 && lat < 30) begin
        @(posedge clk);
        #1;
        lat++;
      end
      n_cmp++;
      if (lat != 8 || t_q !== qs[i] || t_r !== 8'h00 || {t_dbz, t_ovf} !== 2'b00) begin
        n_err++;
        $display("FAIL trunc_%0d: got lat=%0d q=%h r=%h flags=%b expected lat=8 q=%h r=00 flags=00",
                 i, lat, t_q, t_r, {t_dbz, t_ovf}, qs[i]);
      end
      @(negedge clk);
      t_out_ready = 1'b1;
      @(posedge clk);
      #1;
      t_out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(16'h1234, 8'h56);
    wait_valid(lat);
    @(negedge clk);
    z = 16'h0100; y = 8'h02; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b10 || {q, r} !== 16'h3610 || {div_by_zero, overflow} !== 2'b00) begin
        n_err++;
        $display("FAIL hold_cycle_%0d: got vld/rdy=%b q=%h r=%h flags=%b expected vld/rdy=10 q=36 r=10 flags=00",
                 i, {out_valid, in_ready}, q, r, {div_by_zero, overflow});
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume();
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL release_idle: got rdy/vld %b expected 10", {in_ready, out_valid}); end
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stray_not_accepted: got in_ready %b expected 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    time t_a, t_b;
    out_ready = 1'b1;
    issue(16'h1234, 8'h56);
    t_a = $time;
    wait_valid(lat);
    issue(16'h0064, 8'h07);
    t_b = $time;
    wait_valid(lat);
    n_cmp++; if (t_b - t_a != 100) begin n_err++; $display("FAIL b2b_spacing: got %0t expected 100", t_b - t_a); end
    n_cmp++; if (lat != 8 || {q, r} !== 16'h0E02) begin n_err++; $display("FAIL b2b_second: got lat=%0d qr=%h expected lat=8 qr=0E02", lat, {q, r}); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(16'h1234, 8'h56);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10 || {q, r} !== 16'h0000 || {div_by_zero, overflow} !== 2'b00) begin
      n_err++;
      $display("FAIL async_reset: got rdy/vld=%b q=%h r=%h flags=%b expected rdy/vld=10 q=00 r=00 flags=00",
               {in_ready, out_valid}, q, r, {div_by_zero, overflow});
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h00FF, 8'h10);
    wait_valid(lat);
    n_cmp++; if (lat != 8 || {q, r} !== 16'h0F0F) begin n_err++; $display("FAIL post_reset_div: got lat=%0d qr=%h expected lat=8 qr=0F0F", lat, {q, r}); end
    consume();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; z = '0; y = '0;
    t_in_valid = 1'b0; t_out_ready = 1'b0; t_z = '0; t_y = '0;
    test_reset();
    test_normal();
    test_full_scale();
    test_products();
    test_exceptions();
    test_trunc();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
